// File: rtl/branch_unit.sv
// Branch unit: latches the ALU Z/V/N status, owns the program counter and
// executes conditional branches through a start/done handshake.
module branch_unit #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_status,
   input  logic            Z_in,
   input  logic            V_in,
   input  logic            N_in,
   input  logic            incr,
   input  logic            start,
   input  logic [2:0]      cond,
   input  logic [7:0]      imm8,
   output logic [PC_W-1:0] pc_out,
   output logic [2:0]      status_out,
   output logic            busy,
   output logic            taken,
   output logic            done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EVAL   = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   localparam logic [2:0] C_B   = 3'b000;
   localparam logic [2:0] C_BEQ = 3'b001;
   localparam logic [2:0] C_BNE = 3'b010;
   localparam logic [2:0] C_BLT = 3'b011;
   localparam logic [2:0] C_BLE = 3'b100;

   logic [1:0]      state;
   logic [PC_W-1:0] pc_q;
   logic [2:0]      status_q;
   logic [2:0]      snap_q;
   logic [2:0]      cond_q;
   logic [7:0]      imm_q;
   logic            taken_q;
   logic            done_q;
   logic            cond_met;
   logic            snap_z, snap_v, snap_n;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] pc_next;

   assign {snap_z, snap_v, snap_n} = snap_q;

   always_comb begin
      // NOTE: default assignment first so every path drives cond_met and no latch is inferred.
      cond_met = 1'b0;
      case (cond_q)
         C_B:     cond_met = 1'b1;
         C_BEQ:   cond_met = snap_z;
         C_BNE:   cond_met = ~snap_z;
         C_BLT:   cond_met = snap_n ^ snap_v;
         C_BLE:   cond_met = (snap_n ^ snap_v) | snap_z;
         default: cond_met = 1'b0;
      endcase
   end

   // Sign-extend the offset; the sum wraps naturally at PC_W bits.
   assign offset  = taken_q ? PC_W'($signed(imm_q)) : '0;
   assign pc_next = pc_q + PC_W'(1) + offset;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         pc_q     <= '0;
         status_q <= '0;
         snap_q   <= '0;
         cond_q   <= '0;
         imm_q    <= '0;
         taken_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_status)
            status_q <= {Z_in, V_in, N_in};
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cond_q <= cond;
                  imm_q  <= imm8;
                  snap_q <= status_q;
                  state  <= ST_EVAL;
               end else if (incr) begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            ST_EVAL: begin
               taken_q <= cond_met;
               state   <= ST_UPDATE;
            end
            ST_UPDATE: begin
               pc_q   <= pc_next;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pc_out     = pc_q;
   assign status_out = status_q;
   assign busy       = (state != ST_IDLE);
   assign taken      = taken_q;
   assign done       = done_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand-written
// multi-cycle corner cases, and randomized traffic against a behavioural model.
module tb_branch_unit;

   localparam int PC_W   = 9;
   localparam int PC_MOD = 1 << PC_W;

   logic            clk;
   logic            reset;
   logic            load_status;
   logic            Z_in, V_in, N_in;
   logic            incr;
   logic            start;
   logic [2:0]      cond;
   logic [7:0]      imm8;
   logic [PC_W-1:0] pc_out;
   logic [2:0]      status_out;
   logic            busy;
   logic            taken;
   logic            done;

   int tests = 0;
   int fails = 0;

   branch_unit #(.PC_W(PC_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_status (load_status),
      .Z_in        (Z_in),
      .V_in        (V_in),
      .N_in        (N_in),
      .incr        (incr),
      .start       (start),
      .cond        (cond),
      .imm8        (imm8),
      .pc_out      (pc_out),
      .status_out  (status_out),
      .busy        (busy),
      .taken       (taken),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] st;
      logic [2:0] c;
      int         imm;
      int         pc0;
      bit         exp_taken;
      int         exp_pc;
   } vec_t;

   vec_t vecs[10];

   // Reference model state
   int         pc_m;
   logic [2:0] st_m;
   bit         taken_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_taken(input logic [2:0] c, input logic [2:0] st);
      bit z, v, n;
      z = st[2];
      v = st[1];
      n = st[0];
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return n != v;
         3'd4:    return (n != v) || z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int model_pc(input int pc, input bit tk, input int off);
      int s;
      s = pc + 1 + (tk ? off : 0);
      return ((s % PC_MOD) + PC_MOD) % PC_MOD;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic goto_pc(input int p);
      do_reset();
      incr = 1'b1;
      repeat (p) tick();
      incr = 1'b0;
   endtask

   task automatic load_flags(input logic [2:0] st);
      load_status = 1'b1;
      {Z_in, V_in, N_in} = st;
      tick();
      load_status = 1'b0;
      check("load_flags status", 32'(status_out), 32'(st));
   endtask

   task automatic run_branch(input string name, input logic [2:0] c, input int imm,
                             input bit exp_tk, input int exp_pc);
      start = 1'b1;
      cond  = c;
      imm8  = 8'(imm);
      tick();
      start = 1'b0;
      check({name, " busy@k"}, 32'(busy), 32'd1);
      check({name, " done@k"}, 32'(done), 32'd0);
      tick();
      check({name, " busy@k+1"}, 32'(busy), 32'd1);
      check({name, " done@k+1"}, 32'(done), 32'd0);
      tick();
      check({name, " done@k+2"}, 32'(done), 32'd1);
      check({name, " busy@k+2"}, 32'(busy), 32'd0);
      check({name, " taken"}, 32'(taken), 32'(exp_tk));
      check({name, " pc"}, 32'(pc_out), 32'(exp_pc));
      tick();
      check({name, " done@k+3"}, 32'(done), 32'd0);
   endtask

   task automatic rand_load();
      logic [2:0] fl;
      if ($urandom_range(0, 2) == 0) begin
         fl = 3'($urandom_range(0, 7));
         load_status = 1'b1;
         {Z_in, V_in, N_in} = fl;
         st_m = fl;
      end else begin
         load_status = 1'b0;
      end
   endtask

   initial begin
      int dones;
      reset = 1'b1; load_status = 1'b0; Z_in = 1'b0; V_in = 1'b0; N_in = 1'b0;
      incr = 1'b0; start = 1'b0; cond = 3'd0; imm8 = 8'd0;

      //              st      cond    imm  pc0  taken pc
      vecs[0] = '{3'b001, 3'b011,   4,  10, 1'b1,  15};  // BLT, flags of 1-32
      vecs[1] = '{3'b011, 3'b011,  -8,  20, 1'b0,  21};  // BLT, signed overflow
      vecs[2] = '{3'b011, 3'b100,  -8,  20, 1'b0,  21};  // BLE, same flags
      vecs[3] = '{3'b000, 3'b111,  50, 511, 1'b0,   0};  // reserved code, wrap
      vecs[4] = '{3'b000, 3'b000,  -2,   0, 1'b1, 511};  // B backwards wrap
      vecs[5] = '{3'b100, 3'b001,   5,  30, 1'b1,  36};  // BEQ taken
      vecs[6] = '{3'b100, 3'b010,   5,  30, 1'b0,  31};  // BNE not taken
      vecs[7] = '{3'b100, 3'b101,   5,  30, 1'b0,  31};  // reserved 101
      vecs[8] = '{3'b100, 3'b100, -10,  40, 1'b1,  31};  // BLE on Z
      vecs[9] = '{3'b000, 3'b010, 127, 100, 1'b1, 228};  // BNE max offset

      tick();
      tick();
      reset = 1'b0;

      // Reset state and sequential fetch
      check("reset pc", 32'(pc_out), 32'd0);
      check("reset status", 32'(status_out), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset taken", 32'(taken), 32'd0);
      check("reset done", 32'(done), 32'd0);
      incr = 1'b1;
      repeat (3) tick();
      incr = 1'b0;
      check("fetch pc", 32'(pc_out), 32'd3);

      // start and incr together: start wins, pc only moves at done
      start = 1'b1; incr = 1'b1; cond = 3'b000; imm8 = 8'd4;
      tick();
      start = 1'b0; incr = 1'b0;
      check("start+incr pc@k", 32'(pc_out), 32'd3);
      tick();
      check("start+incr pc@k+1", 32'(pc_out), 32'd3);
      tick();
      check("start+incr pc@k+2", 32'(pc_out), 32'd8);
      check("start+incr done", 32'(done), 32'd1);
      tick();

      // Directed vector table
      foreach (vecs[i]) begin
         goto_pc(vecs[i].pc0);
         load_flags(vecs[i].st);
         run_branch($sformatf("vec%0d", i), vecs[i].c, vecs[i].imm,
                    vecs[i].exp_taken, vecs[i].exp_pc);
      end

      // Reset mid-branch abandons the branch with no done pulse
      goto_pc(5);
      load_flags(3'b111);
      start = 1'b1; cond = 3'b000; imm8 = 8'd4;
      tick();
      start = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset pc", 32'(pc_out), 32'd0);
      check("midreset status", 32'(status_out), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset taken", 32'(taken), 32'd0);
      dones = 0;
      repeat (4) begin
         tick();
         dones += int'(done);
      end
      check("midreset no done", 32'(dones), 32'd0);
      check("midreset pc held", 32'(pc_out), 32'd0);

      // Snapshot isolation: status changes on the EVAL edge do not affect the branch
      goto_pc(8);
      load_flags(3'b100);
      start = 1'b1; cond = 3'b001; imm8 = 8'hFD;
      tick();
      start = 1'b0;
      load_status = 1'b1; {Z_in, V_in, N_in} = 3'b000;
      tick();
      load_status = 1'b0;
      check("snap status_out", 32'(status_out), 32'd0);
      tick();
      check("snap done", 32'(done), 32'd1);
      check("snap taken", 32'(taken), 32'd1);
      check("snap pc", 32'(pc_out), 32'd6);

      // start/incr held high through a busy branch: exactly one done
      goto_pc(50);
      start = 1'b1; incr = 1'b1; cond = 3'b000; imm8 = 8'd6;
      dones = 0;
      repeat (3) begin
         tick();
         dones += int'(done);
      end
      start = 1'b0; incr = 1'b0;
      repeat (4) begin
         tick();
         dones += int'(done);
      end
      check("held start dones", 32'(dones), 32'd1);
      check("held start pc", 32'(pc_out), 32'd57);

      // Back-to-back start in the cycle right after done
      do_reset();
      start = 1'b1; cond = 3'b000; imm8 = 8'd1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("b2b first pc", 32'(pc_out), 32'd2);
      start = 1'b1; cond = 3'b111; imm8 = 8'd9;
      tick();
      start = 1'b0;
      check("b2b accepted busy", 32'(busy), 32'd1);
      check("b2b done cleared", 32'(done), 32'd0);
      tick();
      tick();
      check("b2b second done", 32'(done), 32'd1);
      check("b2b second taken", 32'(taken), 32'd0);
      check("b2b second pc", 32'(pc_out), 32'd3);

      // Randomized traffic against the behavioural model
      do_reset();
      pc_m = 0; st_m = 3'b000; taken_m = 1'b0;
      for (int it = 0; it < 300; it++) begin
         int         op;
         int         im;
         logic [2:0] c;
         logic [2:0] snap;
         op = int'($urandom_range(0, 3));
         if (op == 0) begin
            incr = 1'b1;
            rand_load();
            tick();
            incr = 1'b0; load_status = 1'b0;
            pc_m = model_pc(pc_m, 1'b0, 0);
            check("rand incr pc", 32'(pc_out), 32'(pc_m));
            check("rand incr status", 32'(status_out), 32'(st_m));
         end else if (op == 1) begin
            rand_load();
            tick();
            load_status = 1'b0;
            check("rand idle pc", 32'(pc_out), 32'(pc_m));
            check("rand idle taken", 32'(taken), 32'(taken_m));
            check("rand idle done", 32'(done), 32'd0);
         end else begin
            c  = 3'($urandom_range(0, 7));
            im = int'($urandom_range(0, 255));
            if (im > 127) im -= 256;
            snap    = st_m;
            taken_m = model_taken(c, snap);
            start = 1'b1; cond = c; imm8 = 8'(im);
            rand_load();
            tick();
            check("rand br busy", 32'(busy), 32'd1);
            for (int j = 0; j < 2; j++) begin
               start = 1'($urandom_range(0, 1));
               incr  = 1'($urandom_range(0, 1));
               cond  = 3'($urandom_range(0, 7));
               imm8  = 8'($urandom_range(0, 255));
               rand_load();
               tick();
            end
            start = 1'b0; incr = 1'b0; load_status = 1'b0;
            pc_m = model_pc(pc_m, taken_m, im);
            check("rand br done", 32'(done), 32'd1);
            check("rand br taken", 32'(taken), 32'(taken_m));
            check("rand br pc", 32'(pc_out), 32'(pc_m));
            check("rand br status", 32'(status_out), 32'(st_m));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
